// File: rtl/plate_ctrl.sv
// Paddle position controller: synchronised, debounced up/down buttons drive a clamped y position once per movement tick.
// Optional build macro PLATE_ACCEL_EN doubles the step after 8 ticks of continuous movement in one direction.
module plate_ctrl #(
   parameter int Y_MAX           = 220,
   parameter int PLATE_HALFWIDTH = 21,
   parameter int Y_INIT          = 110,
   parameter int STEP            = 2,
   parameter int TICK_DIV        = 200000,
   parameter int DEB_CYCLES      = 50000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       freeze,
   output logic [7:0] y_p_mid,
   output logic       moving
);

   localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [8:0] Y_HI = 9'(Y_MAX - PLATE_HALFWIDTH);
   localparam logic [8:0] Y_LO = 9'(PLATE_HALFWIDTH);

   typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;

   logic [1:0]    btn_raw;
   logic [1:0]    btn_deb;
   logic [TW-1:0] tick_cnt_reg;
   logic          tick;
   state_t        state_reg, state_next;
   logic [8:0]    step_val;
   logic [8:0]    y_sum, y_dif;
   logic [7:0]    y_reg, y_next;

   assign btn_raw = {btn_down, btn_up};

   // Bit 0 is the up button, bit 1 the down button.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_btn
         logic          s1_reg, s2_reg, deb_reg;
         logic [DW-1:0] cnt_reg;

         always_ff @(posedge clk) begin
            if (rst) begin
               s1_reg  <= 1'b0;
               s2_reg  <= 1'b0;
               deb_reg <= 1'b0;
               cnt_reg <= '0;
            end else begin
               s1_reg <= btn_raw[gi];
               s2_reg <= s1_reg;
               if (s2_reg == deb_reg) begin
                  cnt_reg <= '0;
               end else if (cnt_reg == DW'(DEB_CYCLES - 1)) begin
                  // This differing sample is the DEB_CYCLES-th in a row.
                  deb_reg <= s2_reg;
                  cnt_reg <= '0;
               end else begin
                  cnt_reg <= cnt_reg + DW'(1);
               end
            end
         end

         assign btn_deb[gi] = deb_reg;
      end
   endgenerate

   assign tick = (tick_cnt_reg == TW'(TICK_DIV - 1));

   always_ff @(posedge clk) begin
      if (rst)       tick_cnt_reg <= '0;
      else if (tick) tick_cnt_reg <= '0;
      else           tick_cnt_reg <= tick_cnt_reg + TW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   always_comb begin
      state_next = IDLE;
      if (!freeze) begin
         if (btn_deb[0] && !btn_deb[1])      state_next = UP;
         else if (btn_deb[1] && !btn_deb[0]) state_next = DOWN;
      end
   end

   always_comb begin
      moving = (state_reg == UP) || (state_reg == DOWN);
   end

`ifdef PLATE_ACCEL_EN
   logic [3:0] hold_reg;

   // Counts ticks spent continuously in one movement state; any state change restarts it.
   always_ff @(posedge clk) begin
      if (rst || state_reg == IDLE || state_next != state_reg) hold_reg <= 4'd0;
      else if (tick && hold_reg != 4'd15)                      hold_reg <= hold_reg + 4'd1;
   end

   assign step_val = hold_reg[3] ? 9'(2 * STEP) : 9'(STEP);
`else
   assign step_val = 9'(STEP);
`endif

   // 9-bit arithmetic so neither direction can wrap before clamping.
   assign y_sum = {1'b0, y_reg} + step_val;
   assign y_dif = {1'b0, y_reg} - step_val;

   always_comb begin
      y_next = y_reg;
      if (tick && state_reg == UP) begin
         y_next = (y_sum > Y_HI) ? Y_HI[7:0] : y_sum[7:0];
      end else if (tick && state_reg == DOWN) begin
         y_next = ({1'b0, y_reg} < Y_LO + step_val) ? Y_LO[7:0] : y_dif[7:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) y_reg <= 8'(Y_INIT);
      else     y_reg <= y_next;
   end

   assign y_p_mid = y_reg;

endmodule

// File: tb/tb_plate_ctrl.sv
// Scoreboard bench for plate_ctrl: expected y_p_mid values are queued by the stimulus and
// consumed by a monitor on every change of y_p_mid.
module tb_plate_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       btn_up = 1'b0;
   logic       btn_down = 1'b0;
   logic       freeze = 1'b0;
   logic [7:0] y_p_mid;
   logic       moving;

   always #5 clk = ~clk;

   plate_ctrl #(.TICK_DIV(4), .DEB_CYCLES(3)) dut (
      .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down),
      .freeze(freeze), .y_p_mid(y_p_mid), .moving(moving)
   );

`ifdef PLATE_ACCEL_EN
   localparam bit ACCEL = 1'b1;
`else
   localparam bit ACCEL = 1'b0;
`endif

   int         checks = 0;
   int         errors = 0;
   int         exp_q[$];
   int         exp_y = 110;
   bit         mon_en = 1'b0;
   logic [7:0] prev_y;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every change of y_p_mid is one transaction checked against the queue.
   always @(negedge clk) begin
      if (mon_en && y_p_mid !== prev_y) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_move: actual=%0d expected=%0d (no move queued)", y_p_mid, prev_y);
         end else begin
            int e;
            e = exp_q.pop_front();
            chk("y_p_mid", int'(y_p_mid), e);
         end
         $display("move: y_p_mid=%0d moving=%0d t=%0t", y_p_mid, moving, $time);
         prev_y = y_p_mid;
      end
   end

   // Queue the positions a continuous press should produce from exp_y until target is reached.
   task automatic push_seq(input int dir, input int target);
      int v, h, st, last;
      v = exp_y;
      h = 0;
      for (int i = 0; i < 300 && v != target; i++) begin
         last = v;
         st = (ACCEL && h >= 8) ? 4 : 2;
         if (dir > 0) v = (v + st > 199) ? 199 : v + st;
         else         v = (v - st < 21)  ? 21  : v - st;
         if (h < 15) h++;
         if (v == last) break;
         exp_q.push_back(v);
      end
      exp_y = v;
   endtask

   task automatic wait_y(input string name, input int target, input int budget, input bit glitch);
      int n;
      n = 0;
      while (int'(y_p_mid) != target && n < budget) begin
         @(negedge clk);
         n++;
         if (glitch) btn_down = ((n % 7) < 2);
      end
      btn_down = glitch ? 1'b0 : btn_down;
      chk(name, int'(y_p_mid), target);
   endtask

   task automatic stop_move();
      freeze = 1'b1;
      @(negedge clk);
      btn_up = 1'b0;
      btn_down = 1'b0;
      repeat (12) @(negedge clk);
      freeze = 1'b0;
      repeat (3) @(negedge clk);
      chk("queue_drained", exp_q.size(), 0);
   endtask

   task automatic do_reset();
      if (exp_y != 110) exp_q.push_back(110);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_y = 110;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset and idle
      repeat (3) @(negedge clk);
      chk("reset_y", int'(y_p_mid), 110);
      chk("reset_moving", int'(moving), 0);
      prev_y = y_p_mid;
      mon_en = 1'b1;
      rst = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (i % 20 == 19) begin
            chk("idle_y", int'(y_p_mid), 110);
            chk("idle_moving", int'(moving), 0);
         end
      end

      // Up press with short down glitches that must never be accepted
      btn_up = 1'b1;
      push_seq(1, 130);
      wait_y("reach_130_glitch", 130, 400, 1'b1);
      chk("moving_up", int'(moving), 1);
      stop_move();

      // Down press clamps at the lower bound and stays there
      btn_down = 1'b1;
      push_seq(-1, 21);
      wait_y("reach_21", 21, 600, 1'b0);
      repeat (200) @(negedge clk);
      chk("hold_low_y", int'(y_p_mid), 21);
      chk("moving_down", int'(moving), 1);
      stop_move();

      // Up press from reset passes 198 and clamps at 199
      do_reset();
      btn_up = 1'b1;
      push_seq(1, 199);
      wait_y("reach_199", 199, 600, 1'b0);
      repeat (100) @(negedge clk);
      chk("hold_high_y", int'(y_p_mid), 199);
      stop_move();

      // Both buttons, then freeze with up held
      do_reset();
      btn_up = 1'b1;
      btn_down = 1'b1;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (i % 15 == 14) chk("both_moving", int'(moving), 0);
      end
      freeze = 1'b1;
      btn_down = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (i % 15 == 14) chk("freeze_moving", int'(moving), 0);
      end
      chk("freeze_y", int'(y_p_mid), 110);
      freeze = 1'b0;
      push_seq(1, 112);
      wait_y("unfreeze_move", 112, 12, 1'b0);
      stop_move();

      // Reset in the middle of an up movement
      do_reset();
      btn_up = 1'b1;
      push_seq(1, 134);
      wait_y("reach_134", 134, 300, 1'b0);
      exp_q.push_back(110);
      rst = 1'b1;
      @(negedge clk);
      chk("midmove_reset_y", int'(y_p_mid), 110);
      chk("midmove_reset_moving", int'(moving), 0);
      rst = 1'b0;
      exp_y = 110;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("debounce_latency_moving", int'(moving), 0);
      end
      begin
         int n;
         n = 0;
         while (!moving && n < 10) begin
            @(negedge clk);
            n++;
         end
         chk("resume_moving", int'(moving), 1);
      end
      push_seq(1, 112);
      wait_y("resume_move", 112, 20, 1'b0);
      stop_move();

      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
